program_sequencer: RTL and testbench

//  Global instruction sequencer shared by every cell core in the array. Fetches 16-bit

---
 rtl/program_sequencer.sv | 173 +++++++++++++++++
 tb/tb_program_sequencer.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_sequencer.sv
// program_sequencer: global instruction sequencer for the cell array.
// Fetches 16-bit instructions from a synchronous ROM, broadcasts each one with a
// single-cycle execution_enable strobe and owns the global PC and return stack.
// Instruction format: opcode in [15:12]; UNL=4'hA (imm8 in [7:0]),
// JUMP=4'hB and CALL=4'hC (target in [11:0]), RET=4'hD; 16'h0000 is NOP;
// every other opcode just advances the PC.
module program_sequencer #(
  parameter int PC_LENGTH = 12,
  parameter int SP_LENGTH = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [PC_LENGTH-1:0] imem_addr,
  input  logic [15:0]          imem_data,
  input  logic                 all_diverge,
  output logic [15:0]          instruction,
  output logic [PC_LENGTH-1:0] next_program_counter,
  output logic [SP_LENGTH-1:0] next_stack_pointer,
  output logic                 execution_enable,
  output logic                 busy,
  output logic                 halted,
  output logic                 stack_error
);

  localparam logic [3:0]  OP_UNL    = 4'hA;
  localparam logic [3:0]  OP_JUMP   = 4'hB;
  localparam logic [3:0]  OP_CALL   = 4'hC;
  localparam logic [3:0]  OP_RET    = 4'hD;
  localparam logic [15:0] INSTR_NOP = 16'h0000;
  localparam int          STACK_DEPTH = 1 << SP_LENGTH;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT,
    EXEC
  } state_t;

  state_t               state_q, state_d;
  logic [PC_LENGTH-1:0] pc_q, pc_d;
  logic [SP_LENGTH-1:0] sp_q, sp_d;
  logic [15:0]          ir_q, ir_d;
  logic                 halted_q, halted_d;
  logic                 stack_error_q, stack_error_d;
  logic                 push;

  logic [PC_LENGTH-1:0] stack_q [STACK_DEPTH];

  logic [PC_LENGTH-1:0] pc_inc;
  logic [PC_LENGTH-1:0] stack_top;
  logic                 sp_full;
  logic                 sp_empty;
  logic [3:0]           opcode;

  // pc+1 wraps naturally at the top address; the RET target is read combinationally
  // so returning costs no extra cycle.
  assign pc_inc    = pc_q + PC_LENGTH'(1);
  assign stack_top = stack_q[sp_q - SP_LENGTH'(1)];
  assign sp_full   = (sp_q == {SP_LENGTH{1'b1}});
  assign sp_empty  = (sp_q == '0);
  assign opcode    = ir_q[15:12];

  // Sequencing FSM plus the PC/SP/flag next-state logic resolved during EXEC.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    sp_d          = sp_q;
    ir_d          = ir_q;
    halted_d      = halted_q;
    stack_error_d = stack_error_q;
    push          = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d       = FETCH;
          pc_d          = '0;
          sp_d          = '0;
          halted_d      = 1'b0;
          stack_error_d = 1'b0;
        end
      end
      FETCH: begin
        state_d = WAIT;
      end
      WAIT: begin
        ir_d    = imem_data;
        state_d = EXEC;
      end
      EXEC: begin
        state_d = FETCH;
        case (opcode)
          OP_UNL: begin
            pc_d = all_diverge ? PC_LENGTH'(ir_q[7:0]) : pc_inc;
          end
          OP_JUMP: begin
            pc_d = PC_LENGTH'(ir_q[11:0]);
          end
          OP_CALL: begin
            if (sp_full) begin
              halted_d      = 1'b1;
              stack_error_d = 1'b1;
              state_d       = IDLE;
            end else begin
              push = 1'b1;
              sp_d = sp_q + SP_LENGTH'(1);
              pc_d = PC_LENGTH'(ir_q[11:0]);
            end
          end
          OP_RET: begin
            if (sp_empty) begin
              halted_d = 1'b1;
              state_d  = IDLE;
            end else begin
              sp_d = sp_q - SP_LENGTH'(1);
              pc_d = stack_top;
            end
          end
          default: begin
            pc_d = pc_inc;
          end
        endcase
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outside EXEC the array sees NOP and the current PC/SP, so idle cycles never desync cells.
  always_comb begin
    imem_addr            = pc_q;
    execution_enable     = (state_q == EXEC);
    busy                 = (state_q != IDLE);
    halted               = halted_q;
    stack_error          = stack_error_q;
    instruction          = INSTR_NOP;
    next_program_counter = pc_q;
    next_stack_pointer   = sp_q;
    if (state_q == EXEC) begin
      instruction          = ir_q;
      next_program_counter = pc_d;
      next_stack_pointer   = sp_d;
    end
  end

  // State registers; reset overrides everything, including an EXEC in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      sp_q          <= '0;
      ir_q          <= INSTR_NOP;
      halted_q      <= 1'b0;
      stack_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      sp_q          <= sp_d;
      ir_q          <= ir_d;
      halted_q      <= halted_d;
      stack_error_q <= stack_error_d;
    end
  end

  // Return-address stack RAM; contents survive reset, but a push is dropped when reset is asserted.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      stack_q[sp_q] <= pc_inc;
    end
  end

endmodule

// File: tb/tb_program_sequencer.sv
// tb_program_sequencer: drives program_sequencer from a behavioural ROM and checks
// every cycle against an instruction-level model of the sequencer.
module tb_program_sequencer;

  localparam int PC_LENGTH = 12;
  localparam int SP_LENGTH = 2;
  localparam int DEPTH     = 1 << SP_LENGTH;
  localparam int PC_MOD    = 1 << PC_LENGTH;

  localparam logic [3:0]  OP_UNL  = 4'hA;
  localparam logic [3:0]  OP_JUMP = 4'hB;
  localparam logic [3:0]  OP_CALL = 4'hC;
  localparam logic [3:0]  OP_RET  = 4'hD;
  localparam logic [15:0] NOP     = 16'h0000;

  logic                 clk;
  logic                 rst_n;
  logic                 start;
  logic [PC_LENGTH-1:0] imem_addr;
  logic [15:0]          imem_data;
  logic                 all_diverge;
  logic [15:0]          instruction;
  logic [PC_LENGTH-1:0] next_program_counter;
  logic [SP_LENGTH-1:0] next_stack_pointer;
  logic                 execution_enable;
  logic                 busy;
  logic                 halted;
  logic                 stack_error;

  logic [15:0] rom [PC_MOD];

  int vectors     = 0;
  int miscompares = 0;

  // Instruction-level model state
  bit mRunning;
  int mCount;
  int mPc;
  int mSp;
  bit mHalted;
  bit mErr;
  int mStack [DEPTH];

  typedef struct {
    int          addr;
    logic [15:0] word;
    bit          div;
    int          expPc;
    int          expSp;
    bit          expHalt;
  } vec_t;

  vec_t vecs [10];

  program_sequencer #(
    .PC_LENGTH(PC_LENGTH),
    .SP_LENGTH(SP_LENGTH)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .start               (start),
    .imem_addr           (imem_addr),
    .imem_data           (imem_data),
    .all_diverge         (all_diverge),
    .instruction         (instruction),
    .next_program_counter(next_program_counter),
    .next_stack_pointer  (next_stack_pointer),
    .execution_enable    (execution_enable),
    .busy                (busy),
    .halted              (halted),
    .stack_error         (stack_error)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous ROM with one cycle of read latency.
  always @(posedge clk) begin
    imem_data <= rom[imem_addr];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic modelReset();
    mRunning = 1'b0;
    mCount   = 0;
    mPc      = 0;
    mSp      = 0;
    mHalted  = 1'b0;
    mErr     = 1'b0;
  endtask

  task automatic clearRom();
    for (int i = 0; i < PC_MOD; i++) rom[i] = NOP;
  endtask

  // One clock cycle: drive inputs, compare all outputs with the model, advance the model.
  task automatic applyStimulus(input bit st, input bit div, input bit rstN);
    int          expPc;
    int          expSp;
    int          op;
    bit          exec;
    bit          halt;
    logic [15:0] instr;
    @(negedge clk);
    rst_n       = rstN;
    start       = st;
    all_diverge = div;
    #1;
    exec  = 1'b0;
    halt  = 1'b0;
    op    = 0;
    expPc = mPc;
    expSp = mSp;
    instr = NOP;
    if (mRunning) begin
      mCount++;
      exec = (mCount == 3);
    end
    if (exec) begin
      instr = rom[mPc];
      op    = int'(instr[15:12]);
      case (op)
        int'(OP_UNL):  expPc = div ? int'(instr[7:0]) : (mPc + 1) % PC_MOD;
        int'(OP_JUMP): expPc = int'(instr[11:0]);
        int'(OP_CALL): begin
          if (mSp == DEPTH - 1) halt = 1'b1;
          else begin
            expSp = mSp + 1;
            expPc = int'(instr[11:0]);
          end
        end
        int'(OP_RET): begin
          if (mSp == 0) halt = 1'b1;
          else begin
            expSp = mSp - 1;
            expPc = mStack[mSp - 1];
          end
        end
        default: expPc = (mPc + 1) % PC_MOD;
      endcase
    end
    checkOutput("execution_enable", 32'(execution_enable), 32'(exec));
    checkOutput("busy", 32'(busy), 32'(mRunning));
    checkOutput("halted", 32'(halted), 32'(mHalted));
    checkOutput("stack_error", 32'(stack_error), 32'(mErr));
    checkOutput("instruction", 32'(instruction), 32'(instr));
    checkOutput("next_program_counter", 32'(next_program_counter), expPc);
    checkOutput("next_stack_pointer", 32'(next_stack_pointer), expSp);
    if (mRunning && mCount == 1) begin
      checkOutput("imem_addr", 32'(imem_addr), mPc);
    end
    if (!rstN) begin
      modelReset();
    end else if (exec) begin
      if (op == int'(OP_CALL) && !halt) mStack[mSp] = (mPc + 1) % PC_MOD;
      if (halt) begin
        mRunning = 1'b0;
        mHalted  = 1'b1;
        if (op == int'(OP_CALL)) mErr = 1'b1;
      end
      mPc    = expPc;
      mSp    = expSp;
      mCount = 0;
    end else if (!mRunning && st) begin
      mRunning = 1'b1;
      mCount   = 0;
      mPc      = 0;
      mSp      = 0;
      mHalted  = 1'b0;
      mErr     = 1'b0;
    end
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst_n       = 1'b0;
    start       = 1'b0;
    all_diverge = 1'b0;
    @(negedge clk);
    modelReset();
  endtask

  // Main sequence: directed cases, table vectors, then randomized run.
  initial begin
    logic [15:0] w;
    int          r;
    bit          st;
    bit          dv;
    bit          rs;
    rst_n       = 1'b0;
    start       = 1'b0;
    all_diverge = 1'b0;
    for (int i = 0; i < DEPTH; i++) mStack[i] = 0;
    clearRom();
    modelReset();
    applyReset();

    // Reset state
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_exec", 32'(execution_enable), 32'd0);
    checkOutput("rst_halted", 32'(halted), 32'd0);
    checkOutput("rst_stack_error", 32'(stack_error), 32'd0);
    checkOutput("rst_instruction", 32'(instruction), 32'h0);
    checkOutput("rst_npc", 32'(next_program_counter), 32'h0);
    checkOutput("rst_nsp", 32'(next_stack_pointer), 32'h0);

    // Three ALU instructions: strobes on cycles 3,6,9, PC 1,2,3, then RET halts
    clearRom();
    rom[0] = 16'h1234;
    rom[1] = 16'h2001;
    rom[2] = 16'h3ABC;
    rom[3] = 16'hD000;
    applyStimulus(1'b1, 1'b0, 1'b1);
    for (int k = 1; k <= 13; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      if (k == 3 || k == 6 || k == 9) begin
        checkOutput("t1_exec", 32'(execution_enable), 32'd1);
        checkOutput("t1_npc", 32'(next_program_counter), k / 3);
      end
    end
    checkOutput("t1_halted", 32'(halted), 32'd1);

    // Table of single instructions reached through a JUMP at address 0
    vecs[0] = '{'h004, 16'hA020, 1'b1, 'h020, 0, 1'b0};
    vecs[1] = '{'h004, 16'hA020, 1'b0, 'h005, 0, 1'b0};
    vecs[2] = '{'h010, 16'hC100, 1'b0, 'h100, 1, 1'b0};
    vecs[3] = '{'hFFF, 16'h5555, 1'b0, 'h000, 0, 1'b0};
    vecs[4] = '{'h050, 16'hBABC, 1'b0, 'hABC, 0, 1'b0};
    vecs[5] = '{'h020, 16'hD000, 1'b0, 'h020, 0, 1'b1};
    vecs[6] = '{'hFFF, 16'hA0FF, 1'b0, 'h000, 0, 1'b0};
    vecs[7] = '{'h123, 16'hA0FF, 1'b1, 'h0FF, 0, 1'b0};
    vecs[8] = '{'h007, 16'h0000, 1'b0, 'h008, 0, 1'b0};
    vecs[9] = '{'h800, 16'hBF00, 1'b1, 'hF00, 0, 1'b0};
    for (int v = 0; v < 10; v++) begin
      clearRom();
      rom[0]            = {OP_JUMP, 12'(vecs[v].addr)};
      rom[vecs[v].addr] = vecs[v].word;
      applyReset();
      applyStimulus(1'b1, 1'b0, 1'b1);
      for (int k = 1; k <= 5; k++) applyStimulus(1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, vecs[v].div, 1'b1);
      checkOutput($sformatf("vec%0d_exec", v), 32'(execution_enable), 32'd1);
      checkOutput($sformatf("vec%0d_npc", v), 32'(next_program_counter), vecs[v].expPc);
      checkOutput($sformatf("vec%0d_nsp", v), 32'(next_stack_pointer), vecs[v].expSp);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput($sformatf("vec%0d_halted", v), 32'(halted), 32'(vecs[v].expHalt));
      checkOutput($sformatf("vec%0d_busy", v), 32'(busy), 32'(!vecs[v].expHalt));
    end

    // CALL 0x100 at 0x010, RET at 0x100 returns to 0x011, second RET halts
    clearRom();
    rom[0]     = 16'hB010;
    rom['h010] = 16'hC100;
    rom['h100] = 16'hD000;
    rom['h011] = 16'hD000;
    applyReset();
    applyStimulus(1'b1, 1'b0, 1'b1);
    for (int k = 1; k <= 13; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      if (k == 6) begin
        checkOutput("t3_call_npc", 32'(next_program_counter), 32'h100);
        checkOutput("t3_call_nsp", 32'(next_stack_pointer), 32'd1);
      end
      if (k == 9) begin
        checkOutput("t3_ret_npc", 32'(next_program_counter), 32'h011);
        checkOutput("t3_ret_nsp", 32'(next_stack_pointer), 32'd0);
      end
    end
    checkOutput("t3_halted", 32'(halted), 32'd1);
    checkOutput("t3_stack_error", 32'(stack_error), 32'd0);

    // Four nested CALLs with a depth-4 stack: the fourth overflows
    clearRom();
    rom[0]     = 16'hC010;
    rom['h010] = 16'hC020;
    rom['h020] = 16'hC030;
    rom['h030] = 16'hC040;
    applyReset();
    applyStimulus(1'b1, 1'b0, 1'b1);
    for (int k = 1; k <= 13; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      if (k == 12) checkOutput("t4_nsp_full", 32'(next_stack_pointer), 32'd3);
    end
    checkOutput("t4_stack_error", 32'(stack_error), 32'd1);
    checkOutput("t4_halted", 32'(halted), 32'd1);
    checkOutput("t4_busy", 32'(busy), 32'd0);
    checkOutput("t4_sp", 32'(next_stack_pointer), 32'd3);

    // RET at sp 0 halts; start in the halting cycle is ignored; a later start restarts
    clearRom();
    rom[0] = 16'hD000;
    applyReset();
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t5_halted", 32'(halted), 32'd1);
    checkOutput("t5_idle", 32'(busy), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t5_restart_halted", 32'(halted), 32'd0);
    checkOutput("t5_restart_addr", 32'(imem_addr), 32'd0);
    checkOutput("t5_restart_busy", 32'(busy), 32'd1);
    for (int k = 2; k <= 4; k++) applyStimulus(1'b0, 1'b0, 1'b1);

    // Reset asserted during the EXEC of a CALL
    clearRom();
    rom[0] = 16'hC100;
    applyReset();
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t6_busy", 32'(busy), 32'd0);
    checkOutput("t6_exec", 32'(execution_enable), 32'd0);
    checkOutput("t6_npc", 32'(next_program_counter), 32'd0);
    checkOutput("t6_nsp", 32'(next_stack_pointer), 32'd0);
    checkOutput("t6_instruction", 32'(instruction), 32'h0);
    checkOutput("t6_halted", 32'(halted), 32'd0);

    // Randomized programs against the model, with random starts, diverge and resets
    for (int i = 0; i < PC_MOD; i++) begin
      r = $urandom_range(0, 9);
      w = 16'($urandom);
      case (r)
        3:       w[15:12] = OP_UNL;
        4:       w[15:12] = OP_JUMP;
        5, 6:    w[15:12] = OP_CALL;
        7:       w[15:12] = OP_RET;
        default: w[15:12] = 4'($urandom_range(0, 9));
      endcase
      rom[i] = w;
    end
    applyReset();
    for (int c = 0; c < 3000; c++) begin
      st = ($urandom_range(0, 3) == 0);
      dv = ($urandom_range(0, 1) == 1);
      rs = ($urandom_range(0, 299) != 0);
      applyStimulus(st, dv, rs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
